// File: rtl/demux_reg.sv
// demux_reg: registered 1-to-N demultiplexer steering one producer word into
//   one of up to eight per-destination holding registers (1-cycle latency).
// Backpressure: in_ready drops while the selected channel is occupied and not
//   being acknowledged this cycle; with DEMUX_OVERWRITE_EN it never stalls.
// Optional feature macro: DEMUX_OVERWRITE_EN (overwrite occupied channel, pulse ovf).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   s, d, in_valid  producer select / data / valid;  in_ready  accept handshake
//   y0..y7          destination holding registers (absent channels read 0)
//   y_valid, y_ack  per-channel occupied flags and consumer acknowledges
//   drop, ovf       one-cycle pulses: out-of-range select, overwritten channel
module demux_reg #(
  parameter int num_of_ways = 8,
  parameter int length      = 32,
  parameter int siglen      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [siglen-1:0] s,
  input  logic [length-1:0] d,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [length-1:0] y0,
  output logic [length-1:0] y1,
  output logic [length-1:0] y2,
  output logic [length-1:0] y3,
  output logic [length-1:0] y4,
  output logic [length-1:0] y5,
  output logic [length-1:0] y6,
  output logic [length-1:0] y7,
  output logic [7:0]        y_valid,
  input  logic [7:0]        y_ack,
  output logic              drop,
  output logic              ovf
);

  // One bit per channel that actually exists.
  localparam logic [7:0] act_mask = 8'((16'd1 << num_of_ways) - 16'd1);

  logic [length-1:0] y_q [8];
  logic [7:0]        vld_q;
  logic [7:0]        ack_m;
  logic [31:0]       s_ext;
  logic              s_oor;
  logic              sel_vld;
  logic              sel_ack;
  logic              accept;

  assign ack_m = y_ack & act_mask;
  assign s_ext = 32'(s);

  // Look up state of the selected channel with a loop so a wide select
  // never indexes past the 8-entry flag vectors.
  always_comb begin
    s_oor   = (s_ext >= 32'(num_of_ways));
    sel_vld = 1'b0;
    sel_ack = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (s_ext == 32'(k)) begin
        sel_vld = vld_q[k];
        sel_ack = ack_m[k];
      end
    end
  end

`ifdef DEMUX_OVERWRITE_EN
  assign in_ready = !rst;
`else
  // An ack in the same cycle frees the slot, giving one word per cycle.
  assign in_ready = !rst && (s_oor || !sel_vld || sel_ack);
`endif

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) y_q[k] <= '0;
      vld_q <= '0;
      drop  <= 1'b0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (k < num_of_ways) begin
          if (accept && (s_ext == 32'(k))) begin
            // New word wins over a same-cycle ack: the ack consumed the old one.
            y_q[k]   <= d;
            vld_q[k] <= 1'b1;
          end else if (ack_m[k]) begin
            // Data is kept; only the occupied flag is released.
            vld_q[k] <= 1'b0;
          end
        end
      end
      drop <= accept && s_oor;
    end
  end

`ifdef DEMUX_OVERWRITE_EN
  logic ovf_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= accept && !s_oor && sel_vld && !sel_ack;
    end
  end
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  // Absent channels always read as zero, even before the first reset.
  assign y0 = act_mask[0] ? y_q[0] : '0;
  assign y1 = act_mask[1] ? y_q[1] : '0;
  assign y2 = act_mask[2] ? y_q[2] : '0;
  assign y3 = act_mask[3] ? y_q[3] : '0;
  assign y4 = act_mask[4] ? y_q[4] : '0;
  assign y5 = act_mask[5] ? y_q[5] : '0;
  assign y6 = act_mask[6] ? y_q[6] : '0;
  assign y7 = act_mask[7] ? y_q[7] : '0;
  assign y_valid = vld_q & act_mask;

endmodule

// File: tb/tb_demux_reg.sv
// Testbench for demux_reg: directed scenarios plus randomized traffic checked
// against a behavioural model of the channel slots (6 ways, 32-bit words).
// DEMUX_OVERWRITE_EN selects the overwrite-mode expectations.
module tb_demux_reg;

  localparam int NW = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  s;
  logic [31:0] d;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] y0, y1, y2, y3, y4, y5, y6, y7;
  logic [7:0]  y_valid;
  logic [7:0]  y_ack;
  logic        drop;
  logic        ovf;

  demux_reg #(.num_of_ways(NW), .length(32), .siglen(3)) dut (
    .clk(clk), .rst(rst), .s(s), .d(d), .in_valid(in_valid), .in_ready(in_ready),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5), .y6(y6), .y7(y7),
    .y_valid(y_valid), .y_ack(y_ack), .drop(drop), .ovf(ovf)
  );

  always #5 clk = ~clk;

  logic [31:0] yo [8];
  assign yo[0] = y0; assign yo[1] = y1; assign yo[2] = y2; assign yo[3] = y3;
  assign yo[4] = y4; assign yo[5] = y5; assign yo[6] = y6; assign yo[7] = y7;

`ifdef DEMUX_OVERWRITE_EN
  localparam bit OVW = 1'b1;
`else
  localparam bit OVW = 1'b0;
`endif

  // Reference model: what each destination slot holds and whether it is full.
  logic [31:0] slot_data [8];
  bit          slot_full [8];
  bit          exp_drop;
  bit          exp_ovf;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check the handshake, advance the model and
  // the DUT by one edge, then compare every output against the model.
  task automatic cyc(input logic r, input logic iv, input logic [2:0] ss,
                     input logic [31:0] dd, input logic [7:0] ak);
    bit ready_exp;
    bit in_range;
    int sel;
    logic [7:0] vexp;
    rst = r; in_valid = iv; s = ss; d = dd; y_ack = ak;
    #1;
    sel      = int'(ss);
    in_range = (sel < NW);
    if (r)        ready_exp = 1'b0;
    else if (OVW) ready_exp = 1'b1;
    else          ready_exp = !in_range || !slot_full[sel] || (ak[sel] == 1'b1);
    check("in_ready", {31'd0, in_ready}, {31'd0, ready_exp});

    if (r) begin
      for (int k = 0; k < 8; k++) begin
        slot_data[k] = '0;
        slot_full[k] = 1'b0;
      end
      exp_drop = 1'b0;
      exp_ovf  = 1'b0;
    end else begin
      bit taken;
      taken    = iv && ready_exp;
      exp_drop = taken && !in_range;
      exp_ovf  = OVW && taken && in_range && slot_full[sel] && !ak[sel];
      for (int k = 0; k < NW; k++) begin
        if (ak[k]) slot_full[k] = 1'b0;
      end
      if (taken && in_range) begin
        slot_data[sel] = dd;
        slot_full[sel] = 1'b1;
      end
    end

    @(posedge clk);
    #1;
    vexp = '0;
    for (int k = 0; k < 8; k++) begin
      vexp[k] = slot_full[k];
      check($sformatf("y%0d", k), yo[k], slot_data[k]);
    end
    check("y_valid", {24'd0, y_valid}, {24'd0, vexp});
    check("drop", {31'd0, drop}, {31'd0, exp_drop});
    check("ovf",  {31'd0, ovf},  {31'd0, exp_ovf});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; s = '0; d = '0; y_ack = '0;
    for (int k = 0; k < 8; k++) begin
      slot_data[k] = '0;
      slot_full[k] = 1'b0;
    end
    exp_drop = 1'b0;
    exp_ovf  = 1'b0;

    // Reset held two cycles with a live request that must not be taken.
    cyc(1, 1, 3'd2, 32'hAAAA5555, 8'h00);
    cyc(1, 1, 3'd2, 32'hAAAA5555, 8'h00);
    cyc(0, 0, 3'd0, 32'h0, 8'h00);
    check("rst_yvalid", {24'd0, y_valid}, 32'h0);
    check("rst_y2", y2, 32'h0);

    // Basic steer to channel 5.
    cyc(0, 1, 3'd5, 32'h12345678, 8'h00);
    check("steer_y5", y5, 32'h12345678);
    check("steer_vld", {24'd0, y_valid}, 32'h20);

    // Backpressure on channel 3, then ack-and-accept on the same edge.
    cyc(0, 1, 3'd3, 32'h0000BEEF, 8'h00);
    cyc(0, 1, 3'd3, 32'h0000DEAD, 8'h00);
    check("bp_y3", y3, OVW ? 32'h0000DEAD : 32'h0000BEEF);
    cyc(0, 1, 3'd3, 32'h0000DEAD, 8'h08);
    check("ackacc_y3", y3, 32'h0000DEAD);
    check("ackacc_vld3", {31'd0, y_valid[3]}, 32'h1);
    check("ackacc_ovf", {31'd0, ovf}, 32'h0);

    // Streaming on channel 1 with the consumer acking every cycle.
    for (int i = 1; i <= 3; i++) begin
      cyc(0, 1, 3'd1, 32'(i), 8'h02);
      check($sformatf("stream_y1_%0d", i), y1, 32'(i));
    end

    // Out-of-range select pulses drop once.
    cyc(0, 1, 3'd7, 32'h000000FF, 8'h00);
    check("oor_drop", {31'd0, drop}, 32'h1);
    cyc(0, 0, 3'd0, 32'h0, 8'h00);
    check("oor_drop_end", {31'd0, drop}, 32'h0);

    // Overwrite scenario on channel 0 (stalls in default mode).
    cyc(0, 1, 3'd0, 32'h10, 8'h00);
    cyc(0, 1, 3'd0, 32'h20, 8'h00);
    check("ow_y0", y0, OVW ? 32'h20 : 32'h10);
    check("ow_ovf", {31'd0, ovf}, {31'd0, OVW});

    // Randomized traffic with occasional mid-stream resets.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 39) == 0),
          ($urandom_range(0, 9) < 7),
          3'($urandom_range(0, 7)),
          $urandom,
          8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
